// File: rtl/trace_scheduler.sv
// trace_scheduler
//   Frame sequencer between the object bus and the ray-tracer datapath.
//   A frame request snapshots the object bus and walks the COLS x ROWS block
//   grid in raster order (col fastest). Each block issues one trace task,
//   waits for the matching tagged result, and writes the returned colour to
//   the pixel RAM. Collision flags are OR-accumulated and published at frame
//   end.
//
//   Optional feature macro: TRACE_SCHED_WATCHDOG_EN
//     defined   : WAIT gives up after TIMEOUT cycles, writes FALLBACK_COLOR
//                 and sets the sticky timeout_err for the frame.
//     undefined : WAIT waits indefinitely, timeout_err is tied 0.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   frame_req          frame start request (level, sampled in IDLE only)
//   obj_bus_in/out     live object state / per-frame snapshot
//   task_*             task offer to the tracer (valid/ready, col/row/tag)
//   result_*           tracer result strobe with tag, colour, collision flags
//   pix_we/addr/din    pixel RAM write port, addr = {col,row}
//   busy, frame_done   status; frame_done is a one-cycle pulse
//   collision          OR of result_coll over the last complete frame
//   timeout_err        watchdog fired during the current/last frame
module trace_scheduler #(
    parameter int          COLS           = 128,
    parameter int          ROWS           = 64,
    parameter int          COL_W          = 7,
    parameter int          ROW_W          = 6,
    parameter int          BUS_W          = 128,
    parameter int          TIMEOUT        = 1024,
    parameter logic [11:0] FALLBACK_COLOR = 12'h000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_req,
    input  logic [BUS_W-1:0]       obj_bus_in,
    output logic [BUS_W-1:0]       obj_bus_out,
    output logic                   task_valid,
    input  logic                   task_ready,
    output logic [COL_W-1:0]       task_col,
    output logic [ROW_W-1:0]       task_row,
    output logic                   task_tag,
    input  logic                   result_valid,
    input  logic                   result_tag,
    input  logic [11:0]            result_color,
    input  logic [3:0]             result_coll,
    output logic                   pix_we,
    output logic [COL_W+ROW_W-1:0] pix_addr,
    output logic [11:0]            pix_din,
    output logic                   busy,
    output logic                   frame_done,
    output logic [3:0]             collision,
    output logic                   timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_e;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               tag_q, tag_d;
    logic [BUS_W-1:0]   obj_q, obj_d;
    logic [3:0]         acc_q, acc_d;
    logic [3:0]         coll_q, coll_d;
    logic [11:0]        din_q, din_d;
    logic               task_valid_q, task_valid_d;
    logic               pix_we_q, pix_we_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               res_ok;

`ifdef TRACE_SCHED_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic               tmo_q, tmo_d;
`else
    logic               unused_cfg;
    assign unused_cfg = ^{FALLBACK_COLOR, TIMEOUT[0]};
`endif

    // tag_q flips on task acceptance, so the outstanding task carries ~tag_q.
    assign res_ok = result_valid && (result_tag != tag_q);

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        tag_d        = tag_q;
        obj_d        = obj_q;
        acc_d        = acc_q;
        coll_d       = coll_q;
        din_d        = din_q;
        task_valid_d = 1'b0;
        pix_we_d     = 1'b0;
        frame_done_d = 1'b0;
`ifdef TRACE_SCHED_WATCHDOG_EN
        wd_cnt_d     = wd_cnt_q;
        tmo_d        = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (frame_req) begin
                    obj_d        = obj_bus_in;
                    col_d        = '0;
                    row_d        = '0;
                    acc_d        = '0;
`ifdef TRACE_SCHED_WATCHDOG_EN
                    tmo_d        = 1'b0;
`endif
                    task_valid_d = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (task_ready) begin
                    tag_d   = ~tag_q;
                    state_d = S_WAIT;
`ifdef TRACE_SCHED_WATCHDOG_EN
                    wd_cnt_d = '0;
`endif
                end else begin
                    task_valid_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (res_ok) begin
                    din_d    = result_color;
                    acc_d    = acc_q | result_coll;
                    pix_we_d = 1'b1;
                    state_d  = S_WRITE;
                end
`ifdef TRACE_SCHED_WATCHDOG_EN
                // Give up after TIMEOUT silent cycles; a late result will
                // carry the stale tag and be dropped by res_ok.
                else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
                    din_d    = FALLBACK_COLOR;
                    tmo_d    = 1'b1;
                    pix_we_d = 1'b1;
                    state_d  = S_WRITE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            S_WRITE: begin
                col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
                if (col_q == COL_LAST) begin
                    row_d = row_q + 1'b1;
                end
                if (col_q == COL_LAST && row_q == ROW_LAST) begin
                    frame_done_d = 1'b1;
                    coll_d       = acc_q;
                    state_d      = S_DONE;
                end else begin
                    task_valid_d = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            tag_q        <= 1'b0;
            obj_q        <= '0;
            acc_q        <= '0;
            coll_q       <= '0;
            din_q        <= '0;
            task_valid_q <= 1'b0;
            pix_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef TRACE_SCHED_WATCHDOG_EN
            wd_cnt_q     <= '0;
            tmo_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            tag_q        <= tag_d;
            obj_q        <= obj_d;
            acc_q        <= acc_d;
            coll_q       <= coll_d;
            din_q        <= din_d;
            task_valid_q <= task_valid_d;
            pix_we_q     <= pix_we_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef TRACE_SCHED_WATCHDOG_EN
            wd_cnt_q     <= wd_cnt_d;
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign obj_bus_out = obj_q;
    assign task_valid  = task_valid_q;
    assign task_col    = col_q;
    assign task_row    = row_q;
    assign task_tag    = tag_q;
    assign pix_we      = pix_we_q;
    assign pix_addr    = {col_q, row_q};
    assign pix_din     = din_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign collision   = coll_q;
`ifdef TRACE_SCHED_WATCHDOG_EN
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_trace_scheduler.sv
module tb_trace_scheduler;

    localparam int BC = 128;
    localparam int BR = 64;
    localparam int SC = 8;
    localparam int SR = 4;
    localparam logic [11:0] S_FB = 12'hABC;
    localparam logic [127:0] BUS_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] BUS_B = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Large instance: default grid
    logic         b_frame_req = 1'b0;
    logic [127:0] b_obj_in = '0, b_obj_out;
    logic         b_tv, b_tr = 1'b1, b_ttag, b_we, b_busy, b_fd, b_tmo;
    logic [6:0]   b_tcol;
    logic [5:0]   b_trow;
    logic         b_rv = 1'b0, b_rtag = 1'b0;
    logic [11:0]  b_rcol = '0, b_din;
    logic [3:0]   b_rcoll = '0, b_coll;
    logic [12:0]  b_addr;

    // Small instance: 8x4 grid, short watchdog, distinct fallback colour
    logic         s_frame_req = 1'b0;
    logic [127:0] s_obj_in = '0, s_obj_out;
    logic         s_tv, s_tr = 1'b1, s_ttag, s_we, s_busy, s_fd, s_tmo;
    logic [2:0]   s_tcol;
    logic [1:0]   s_trow;
    logic         s_rv = 1'b0, s_rtag = 1'b0;
    logic [11:0]  s_rcol = '0, s_din;
    logic [3:0]   s_rcoll = '0, s_coll;
    logic [4:0]   s_addr;

    trace_scheduler u_big (
        .clk(clk), .rst(rst), .frame_req(b_frame_req),
        .obj_bus_in(b_obj_in), .obj_bus_out(b_obj_out),
        .task_valid(b_tv), .task_ready(b_tr), .task_col(b_tcol), .task_row(b_trow), .task_tag(b_ttag),
        .result_valid(b_rv), .result_tag(b_rtag), .result_color(b_rcol), .result_coll(b_rcoll),
        .pix_we(b_we), .pix_addr(b_addr), .pix_din(b_din),
        .busy(b_busy), .frame_done(b_fd), .collision(b_coll), .timeout_err(b_tmo)
    );

    trace_scheduler #(
        .COLS(SC), .ROWS(SR), .COL_W(3), .ROW_W(2), .BUS_W(128),
        .TIMEOUT(16), .FALLBACK_COLOR(S_FB)
    ) u_sm (
        .clk(clk), .rst(rst), .frame_req(s_frame_req),
        .obj_bus_in(s_obj_in), .obj_bus_out(s_obj_out),
        .task_valid(s_tv), .task_ready(s_tr), .task_col(s_tcol), .task_row(s_trow), .task_tag(s_ttag),
        .result_valid(s_rv), .result_tag(s_rtag), .result_color(s_rcol), .result_coll(s_rcoll),
        .pix_we(s_we), .pix_addr(s_addr), .pix_din(s_din),
        .busy(s_busy), .frame_done(s_fd), .collision(s_coll), .timeout_err(s_tmo)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc;

    // Tracer model and write-checker state
    bit   bp, wd_mode, pend, late_pend, have_tag, last_hs;
    int   p_col, p_row, p_dly, last_hc, last_hr, coll_col, coll_row;
    logic p_tag, late_tag, last_tag;
    bit   seen [BC*BR];
    int   next_idx, wr_cnt, order_err, dup_err, data_err, stab_err, tag_err;
    int   fd_cnt, fd_cyc, hs00_cyc, we00_cyc;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] color_of(input bit big, input int col, input int row);
        int v;
        v = row * (big ? BC : SC) + col;
        return v[11:0];
    endfunction

    task automatic clear_frame();
        foreach (seen[i]) seen[i] = 1'b0;
        next_idx = 0; wr_cnt = 0; order_err = 0; dup_err = 0; data_err = 0;
        stab_err = 0; tag_err = 0; fd_cnt = 0; fd_cyc = -1;
        have_tag = 1'b0; pend = 1'b0; late_pend = 1'b0;
    endtask

    // One clock: note the handshake before the edge, check outputs #1 after
    // it, then drive the tracer's response for the next edge.
    task automatic step(input bit big);
        bit tv, tr, we, fd, hs, hold, rv, nr;
        int tc, trw, ac, ar, idx, pc, pr;
        logic tg, pt, rtg;
        logic [11:0] din, expc, rc;
        logic [3:0] rk;
        if (big) begin tv = b_tv; tr = b_tr; tc = int'(b_tcol); trw = int'(b_trow); tg = b_ttag; end
        else     begin tv = s_tv; tr = s_tr; tc = int'(s_tcol); trw = int'(s_trow); tg = s_ttag; end
        hs = tv && tr; hold = tv && !tr; pc = tc; pr = trw; pt = tg;
        last_hs = hs; last_hc = pc; last_hr = pr;
        @(posedge clk); #1; cyc++;
        if (big) begin
            tv = b_tv; tc = int'(b_tcol); trw = int'(b_trow); tg = b_ttag; we = b_we;
            ac = int'(b_addr[12:6]); ar = int'(b_addr[5:0]); din = b_din; fd = b_fd;
        end else begin
            tv = s_tv; tc = int'(s_tcol); trw = int'(s_trow); tg = s_ttag; we = s_we;
            ac = int'(s_addr[4:2]); ar = int'(s_addr[1:0]); din = s_din; fd = s_fd;
        end
        if (hold && !(tv && tc == pc && trw == pr && tg == pt)) stab_err++;
        if (we) begin
            idx = ar * (big ? BC : SC) + ac;
            if (seen[idx]) dup_err++;
            seen[idx] = 1'b1;
            if (idx != next_idx) order_err++;
            next_idx = idx + 1;
            expc = (wd_mode && idx == 0) ? S_FB : color_of(big, ac, ar);
            if (din != expc) data_err++;
            if (idx == 0) we00_cyc = cyc;
            wr_cnt++;
        end
        if (fd) begin fd_cnt++; fd_cyc = cyc; end

        rv = 1'b0; rtg = 1'b0; rc = '0; rk = '0;
        if (hs) begin
            if (have_tag && pt == last_tag) tag_err++;
            last_tag = pt; have_tag = 1'b1;
            if (pc == 0 && pr == 0) hs00_cyc = cyc;
            if (wd_mode && pc == 0 && pr == 0) begin
                late_pend = 1'b1; late_tag = pt;   // tracer stays silent
            end else begin
                pend = 1'b1; p_col = pc; p_row = pr; p_tag = pt;
                p_dly = bp ? int'($urandom_range(0, 3)) : 0;
            end
        end
        if (pend) begin
            if (late_pend) begin
                rv = 1'b1; rtg = late_tag; rc = 12'hFFF; rk = 4'hF; late_pend = 1'b0;
            end else if (p_dly == 0) begin
                rv = 1'b1; rtg = p_tag; rc = color_of(big, p_col, p_row);
                rk = (p_col == coll_col && p_row == coll_row) ? 4'b0100 : 4'b0000;
                pend = 1'b0;
            end else begin
                p_dly--;
                if (bp && $urandom_range(0, 1) == 1) begin
                    rv = 1'b1; rtg = ~p_tag; rc = 12'hFFF; rk = 4'hF;
                end
            end
        end else if (bp && $urandom_range(0, 1) == 1) begin
            rv = 1'b1; rtg = ($urandom_range(0, 1) == 1); rc = 12'hFFF; rk = 4'hF;
        end
        nr = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (big) begin b_rv = rv; b_rtag = rtg; b_rcol = rc; b_rcoll = rk; b_tr = nr; end
        else     begin s_rv = rv; s_rtag = rtg; s_rcol = rc; s_rcoll = rk; s_tr = nr; end
    endtask

    initial begin
        bp = 1'b0; wd_mode = 1'b0; coll_col = -1; coll_row = -1; cyc = 0;
        hs00_cyc = -100; we00_cyc = -200; last_tag = 1'b0; late_tag = 1'b0;
        p_tag = 1'b0; p_col = 0; p_row = 0; p_dly = 0; last_hs = 1'b0; last_hc = 0; last_hr = 0;
        clear_frame();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_big_out", {b_busy, b_tv, b_we, b_fd, b_coll, b_tmo, b_ttag, b_tcol, b_trow, b_addr, b_din}, '0);
        chk("rst_big_bus", b_obj_out, '0);
        chk("rst_sm_out", {s_busy, s_tv, s_we, s_fd, s_coll, s_tmo, s_obj_out}, '0);
        rst = 1'b1;

        // Frame 1 (large): ideal tracer, collision on block (5,3), bus change
        // mid-frame; frame_req held high so frame 2 follows back-to-back.
        coll_col = 5; coll_row = 3; b_obj_in = BUS_A; b_frame_req = 1'b1; cyc = 0;
        step(1);
        chk("f1_start", {b_busy, b_tv, b_tcol, b_trow}, {1'b1, 1'b1, 7'd0, 6'd0});
        chk("f1_snapshot", b_obj_out, BUS_A);
        repeat (999) step(1);
        b_obj_in = BUS_B;
        repeat (100) step(1);
        chk("f1_bus_hold_mid", b_obj_out, BUS_A);
        while (fd_cnt == 0 && cyc < 30000) step(1);
        chk("f1_done_seen", fd_cnt, 1);
        // frame_req's own cycle is cycle 1, so cycle 24578 is cyc 24577 here
        chk("f1_done_cycle", fd_cyc, 24577);
        chk("f1_writes", wr_cnt, BC * BR);
        chk("f1_order_dup_data", {order_err, dup_err, data_err, tag_err}, '0);
        chk("f1_collision", b_coll, 4'b0100);
        chk("f1_bus_hold_end", b_obj_out, BUS_A);
        step(1);
        chk("f1_idle_after", b_busy, 1'b0);
        clear_frame(); coll_col = -1; coll_row = -1;
        step(1);
        b_frame_req = 1'b0;
        chk("f2_autostart", {b_busy, b_tv}, 2'b11);
        chk("f2_snapshot", b_obj_out, BUS_B);
        repeat (50) step(1);
        chk("f2_coll_holds", b_coll, 4'b0100);
        while (fd_cnt == 0 && cyc < 60000) step(1);
        chk("f2_done_cycle", fd_cyc, 49155);
        chk("f2_writes", wr_cnt, BC * BR);
        chk("f2_order_dup_data", {order_err, dup_err, data_err, tag_err}, '0);
        chk("f2_collision_clear", b_coll, 4'b0000);
        chk("f2_no_timeout", b_tmo, 1'b0);
        step(1);
        chk("f2_idle_after", b_busy, 1'b0);

        // Reset while waiting on block (10,2)
        clear_frame(); b_frame_req = 1'b1;
        step(1);
        b_frame_req = 1'b0;
        begin
            int guard = 0;
            while (!(last_hs && last_hc == 10 && last_hr == 2) && guard < 3000) begin
                step(1); guard++;
            end
        end
        chk("rst_reach_10_2", {last_hs, 7'(last_hc), 6'(last_hr)}, {1'b1, 7'd10, 6'd2});
        #1 rst = 1'b0;
        #1;
        chk("midrst_out", {b_busy, b_tv, b_we, b_fd, b_coll, b_tmo, b_ttag, b_tcol, b_trow, b_addr, b_din}, '0);
        chk("midrst_bus", b_obj_out, '0);
        b_rv = 1'b0; pend = 1'b0;
        @(posedge clk); #1;
        chk("midrst_no_write", {b_we, b_busy}, 2'b00);
        rst = 1'b1;
        clear_frame(); b_frame_req = 1'b1;
        step(1);
        b_frame_req = 1'b0;
        chk("postrst_first_task", {b_busy, b_tv, b_tcol, b_trow, b_ttag}, {1'b1, 1'b1, 7'd0, 6'd0, 1'b0});
        b_tr = 1'b0;

        // Small instance: random backpressure, stray results, mid-frame request
        bp = 1'b1; clear_frame(); cyc = 0; s_obj_in = BUS_A; s_frame_req = 1'b1;
        step(0);
        while (fd_cnt == 0 && cyc < 3000) begin
            s_frame_req = (cyc == 20);
            step(0);
        end
        s_frame_req = 1'b0;
        chk("bp_done_seen", fd_cnt, 1);
        chk("bp_writes", wr_cnt, SC * SR);
        chk("bp_order_dup_data", {order_err, dup_err, data_err}, '0);
        chk("bp_stable_tag", {stab_err, tag_err}, '0);
        chk("bp_collision", s_coll, 4'b0000);
        repeat (10) step(0);
        chk("bp_no_requeue", {fd_cnt, wr_cnt, 31'd0, s_busy}, {32'd1, 32'(SC * SR), 32'd0});
`ifdef TRACE_SCHED_WATCHDOG_EN
        // Silent tracer on block (0,0), late stale-tag result on block (1,0)
        bp = 1'b0; wd_mode = 1'b1; clear_frame(); cyc = 0; s_frame_req = 1'b1;
        step(0);
        s_frame_req = 1'b0;
        while (fd_cnt == 0 && cyc < 3000) step(0);
        chk("wd_done_seen", fd_cnt, 1);
        chk("wd_latency", we00_cyc - hs00_cyc, 16);
        chk("wd_writes", wr_cnt, SC * SR);
        chk("wd_order_dup_data", {order_err, dup_err, data_err}, '0);
        chk("wd_timeout_err", s_tmo, 1'b1);
        chk("wd_late_dropped_coll", s_coll, 4'b0000);
        wd_mode = 1'b0; clear_frame(); s_frame_req = 1'b1;
        step(0);
        s_frame_req = 1'b0;
        chk("wd_err_cleared", s_tmo, 1'b0);
`else
        chk("tmo_tied_zero", {s_tmo, b_tmo}, 2'b00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
